switch_capture: RTL and testbench
=================================

Name: switch_capture

Overview:
- Memory-mapped input-capture responder for the external switch/button port; it is the read-side counterpart of the output path that drives the seven-segment displays.
- Synchronises and debounces up to 32 raw input pins and latches change events.
- Presents four registers on the same 2-bit-address, 32-bit I/O bus the CPU uses for the I/O buffer.
- Raises a level interrupt request on enabled changes.

Parameters:
- WIDTH, 32: number of input pins; register bits above WIDTH read 0.
- DIV, 50000: sample prescaler in CLK cycles; legal range 1 or more.
- SAMPLES, 3: consecutive equal samples needed to accept a new level; legal range 2 to 8.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- PINS  input  WIDTH  raw asynchronous switch inputs.
- SEL  input  1  bus select for this block.
- WE  input  1  write strobe, qualified by SEL.
- ADDRESS  input  2  register select.
- DATAIN  input  32  write data.
- DATAOUT  output  32  read data.
- IRQ  output  1  interrupt request, level.

Behaviour:
- Reset (asynchronous, RST=1): synchroniser flops, sample history, prescaler, STATE, CHANGED, IRQ_EN and EVCOUNT all go to 0. Consequently DATAOUT=0 for every address and IRQ=0. RST asserted mid-debounce discards all partial history.
- Synchroniser: two flops per bit (sync). No other logic sees PINS directly.
- Prescaler: counts 0 to DIV-1 and wraps. tick=1 in the cycle the count equals DIV-1. With DIV=1, tick=1 every cycle.
- Sampling on each tick edge: hist <= {hist[SAMPLES-2:0], sync} per bit.
- Debounce: if all SAMPLES entries of the new history are equal and differ from STATE[i], STATE[i] takes that value on the same edge. Otherwise STATE[i] holds.
- Glitch rejection: any pulse shorter than DIV cycles is sampled at most once and is never accepted.
- Latency: a clean input level change reaches STATE within 2+SAMPLES*DIV cycles and no sooner than 2+(SAMPLES-1)*DIV+1 cycles.
- change vector: chg = bits of STATE that toggle at this edge.
- Register map, reads combinational (DATAOUT follows ADDRESS the same cycle, independent of SEL):
  - 0 STATE: read-only; writes ignored.
  - 1 CHANGED: sticky bit per input, set when that STATE bit toggles. Write-1-to-clear. A set and a clear of the same bit on the same edge leaves the bit 1 (set wins).
  - 2 IRQ_EN: read/write, WIDTH bits.
  - 3 EVCOUNT: counts edges where chg is non-zero; wraps from 0xFFFFFFFF to 0. Any write clears it. A write coinciding with a counted event loads 1.
- Writes take effect on the CLK edge where SEL=1 and WE=1. SEL=0 or WE=0 means no register change.
- IRQ = OR of (CHANGED & IRQ_EN), derived combinationally from registers. It drops the cycle after the last enabled CHANGED bit is cleared or disabled.
- Inputs held high through reset release are reported as a change: STATE rises after debounce, CHANGED sets, EVCOUNT becomes 1.
- Multiple bits toggling on one edge count as one EVCOUNT event.

Test Plan (bench uses DIV=4, SAMPLES=3):
- Release RST with PINS[0]=1 held -> STATE reads 0x1 within 14 cycles, not before cycle 11. CHANGED=0x1, EVCOUNT=1, IRQ=0 (IRQ_EN=0).
- With STATE[5]=0, pulse PINS[5] high for 3 cycles -> STATE, CHANGED and EVCOUNT unchanged for 30 cycles.
- Write IRQ_EN=0x20, then raise PINS[5] steadily -> CHANGED[5]=1, IRQ=1. Write CHANGED=0x20 -> IRQ=0 next cycle, CHANGED=0.
- Arrange a debounce acceptance on bit 2 on the same edge as a CHANGED write of 0x4 -> CHANGED[2]=1 after that edge.
- Toggle PINS[1] and PINS[3] together -> CHANGED=0xA, EVCOUNT increments by exactly 1. Write ADDRESS=3 -> EVCOUNT=0.
- Assert RST while PINS[7] has two of three samples collected -> all registers 0; after release, STATE[7] needs a full 3 fresh samples.

Source files
------------

// File: rtl/switch_capture.sv
// Switch/button input capture: 2-flop sync, prescaled debounce, sticky change flags, event count, level IRQ.
// Latency: clean level reaches STATE in 2+(SAMPLES-1)*DIV+1 .. 2+SAMPLES*DIV cycles; reads are combinational.
module switch_capture #(
    parameter int WIDTH   = 32,
    parameter int DIV     = 50000,
    parameter int SAMPLES = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PINS,
    input  logic             SEL,
    input  logic             WE,
    input  logic [1:0]       ADDRESS,
    input  logic [31:0]      DATAIN,
    output logic [31:0]      DATAOUT,
    output logic             IRQ
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [WIDTH-1:0]              sync1_q, sync2_q;
    logic [WIDTH-1:0][SAMPLES-1:0] hist_q, hist_d;
    logic [PW-1:0]                 presc_q, presc_d;
    logic [WIDTH-1:0]              state_q, state_d;
    logic [WIDTH-1:0]              changed_q, changed_d;
    logic [WIDTH-1:0]              irq_en_q, irq_en_d;
    logic [31:0]                   evcount_q, evcount_d;
    logic [WIDTH-1:0]              chg;
    logic [WIDTH-1:0]              clr_mask;
    logic                          tick;
    logic                          wr_en;
    logic [31:0]                   state_x, changed_x, irq_en_x;

    assign tick  = (presc_q == PW'(DIV - 1));
    assign wr_en = SEL & WE;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // A bit is accepted only when the whole freshly shifted history agrees and differs from STATE.
    always_comb begin
        hist_d  = hist_q;
        state_d = state_q;
        chg     = '0;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][SAMPLES-2:0], sync2_q[i]};
                if (((&hist_d[i]) || !(|hist_d[i])) && (hist_d[i][0] != state_q[i])) begin
                    state_d[i] = hist_d[i][0];
                    chg[i]     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        clr_mask  = (wr_en && ADDRESS == 2'd1) ? DATAIN[WIDTH-1:0] : '0;
        changed_d = (changed_q & ~clr_mask) | chg;
        irq_en_d  = (wr_en && ADDRESS == 2'd2) ? DATAIN[WIDTH-1:0] : irq_en_q;
        if (wr_en && ADDRESS == 2'd3) begin
            evcount_d = {31'd0, |chg};
        end else begin
            evcount_d = evcount_q + {31'd0, |chg};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            presc_q   <= '0;
            state_q   <= '0;
            changed_q <= '0;
            irq_en_q  <= '0;
            evcount_q <= '0;
        end else begin
            sync1_q   <= PINS;
            sync2_q   <= sync1_q;
            hist_q    <= hist_d;
            presc_q   <= presc_d;
            state_q   <= state_d;
            changed_q <= changed_d;
            irq_en_q  <= irq_en_d;
            evcount_q <= evcount_d;
        end
    end

    always_comb begin
        state_x                = '0;
        changed_x              = '0;
        irq_en_x               = '0;
        state_x[WIDTH-1:0]     = state_q;
        changed_x[WIDTH-1:0]   = changed_q;
        irq_en_x[WIDTH-1:0]    = irq_en_q;
        case (ADDRESS)
            2'd0:    DATAOUT = state_x;
            2'd1:    DATAOUT = changed_x;
            2'd2:    DATAOUT = irq_en_x;
            default: DATAOUT = evcount_q;
        endcase
    end

    assign IRQ = |(changed_q & irq_en_q);

endmodule

// File: tb/tb_switch_capture.sv
// Bench for switch_capture: directed scenarios plus random pin/bus traffic against a word-level model.
module tb_switch_capture;
    localparam int WIDTH   = 32;
    localparam int DIV     = 4;
    localparam int SAMPLES = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] PINS;
    logic             SEL, WE;
    logic [1:0]       ADDRESS;
    logic [31:0]      DATAIN;
    logic [31:0]      DATAOUT;
    logic             IRQ;

    always #5 CLK = ~CLK;

    switch_capture #(.WIDTH(WIDTH), .DIV(DIV), .SAMPLES(SAMPLES)) dut (
        .CLK(CLK), .RST(RST), .PINS(PINS), .SEL(SEL), .WE(WE),
        .ADDRESS(ADDRESS), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .IRQ(IRQ)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pins delayed two cycles, sampled every DIV cycles; a bit's level
    // is accepted once the last SAMPLES samples all agree.
    logic [31:0] m_s1, m_s2, m_state, m_changed, m_en, m_ev;
    int          m_cyc;
    logic [31:0] m_hist[$];
    logic [31:0] dut_reg[4];
    logic        dut_irq;
    string       reg_name[4] = '{"STATE", "CHANGED", "IRQ_EN", "EVCOUNT"};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_state = 0; m_changed = 0; m_en = 0; m_ev = 0; m_cyc = 0;
        m_hist = {};
        for (int k = 0; k < SAMPLES; k++) m_hist.push_back(32'h0);
    endtask

    function automatic logic [31:0] pred_chg();
        logic [31:0] a, o;
        if (m_cyc % DIV != DIV - 1) return 32'h0;
        a = m_s2;
        o = m_s2;
        for (int k = 1; k < SAMPLES; k++) begin
            a &= m_hist[k];
            o |= m_hist[k];
        end
        return (a & ~m_state) | (~o & m_state);
    endfunction

    task automatic model_edge();
        logic [31:0] chg, wmask;
        logic        wr;
        chg = pred_chg();
        if (m_cyc % DIV == DIV - 1) begin
            m_hist.push_back(m_s2);
            void'(m_hist.pop_front());
        end
        m_state ^= chg;
        wr    = SEL && WE;
        wmask = (wr && ADDRESS == 2'd1) ? DATAIN : 32'h0;
        m_changed = (m_changed & ~wmask) | chg;
        if (wr && ADDRESS == 2'd2) m_en = DATAIN;
        if (wr && ADDRESS == 2'd3) m_ev = (chg != 0) ? 32'd1 : 32'd0;
        else if (chg != 0)         m_ev = m_ev + 32'd1;
        m_s2 = m_s1;
        m_s1 = PINS;
        m_cyc++;
    endtask

    // One clock: update model at the edge, then read back all registers and IRQ.
    task automatic step();
        logic [31:0] exp_reg[4];
        @(posedge CLK);
        if (RST) model_reset();
        else     model_edge();
        exp_reg = '{m_state, m_changed, m_en, m_ev};
        #1;
        for (int a = 0; a < 4; a++) begin
            ADDRESS = 2'(a);
            #1;
            dut_reg[a] = DATAOUT;
            check(reg_name[a], DATAOUT, exp_reg[a]);
        end
        dut_irq = IRQ;
        check("IRQ", {31'd0, IRQ}, {31'd0, |(m_changed & m_en)});
        SEL = 1'b0;
        WE  = 1'b0;
        ADDRESS = 2'd0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        SEL = 1'b1; WE = 1'b1; ADDRESS = addr; DATAIN = data;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            ADDRESS = 2'(a);
            #1;
            check({tag, "_", reg_name[a]}, DATAOUT, 32'h0);
        end
        check({tag, "_IRQ"}, {31'd0, IRQ}, 32'h0);
    endtask

    initial begin
        int  first;
        bit  found;
        RST = 1'b1; PINS = 32'h1; SEL = 1'b0; WE = 1'b0; ADDRESS = 2'd0; DATAIN = 32'h0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_all_zero("RESET");
        RST = 1'b0;

        // Pin held high through reset release is reported as a change.
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (first == 0 && dut_reg[0][0]) first = n;
        end
        check("LAT_NOT_BEFORE", {31'd0, first >= 2 + (SAMPLES - 1) * DIV + 1}, 32'd1);
        check("LAT_WITHIN", {31'd0, first != 0 && first <= 2 + SAMPLES * DIV}, 32'd1);
        check("T1_STATE", dut_reg[0], 32'h1);
        check("T1_CHANGED", dut_reg[1], 32'h1);
        check("T1_EVCOUNT", dut_reg[3], 32'h1);
        check("T1_IRQ", {31'd0, dut_irq}, 32'h0);

        // Pulse shorter than DIV is rejected.
        PINS[5] = 1'b1;
        repeat (3) step();
        PINS[5] = 1'b0;
        repeat (30) step();
        check("GLITCH_STATE", dut_reg[0], 32'h1);
        check("GLITCH_CHANGED", dut_reg[1], 32'h1);
        check("GLITCH_EVCOUNT", dut_reg[3], 32'h1);

        // Enabled change raises IRQ; W1C drops it after the write edge.
        wr(2'd2, 32'h20);
        PINS[5] = 1'b1;
        repeat (16) step();
        check("IRQ_CHANGED", dut_reg[1], 32'h21);
        check("IRQ_SET", {31'd0, dut_irq}, 32'h1);
        wr(2'd1, 32'h20);
        check("IRQ_CLR", {31'd0, dut_irq}, 32'h0);
        check("IRQ_CLR_CHANGED", dut_reg[1], 32'h1);
        check("IRQ_EVCOUNT", dut_reg[3], 32'h2);

        // Clear of bit 2 on the very edge bit 2 is accepted: set wins.
        PINS[2] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if ((pred_chg() & 32'h4) != 0) begin
                wr(2'd1, 32'h4);
                found = 1'b1;
                check("SETWIN_BIT2", {31'd0, dut_reg[1][2]}, 32'h1);
            end else begin
                step();
            end
        end
        check("SETWIN_ALIGNED", {31'd0, found}, 32'h1);

        // Two bits on one edge are one event; any EVCOUNT write clears.
        wr(2'd1, 32'hFFFF_FFFF);
        PINS[1] = 1'b1;
        PINS[3] = 1'b1;
        repeat (16) step();
        check("MULTI_CHANGED", dut_reg[1], 32'hA);
        check("MULTI_EVCOUNT", dut_reg[3], 32'h4);
        wr(2'd3, 32'h1234);
        check("EV_CLEAR", dut_reg[3], 32'h0);

        // EVCOUNT write on an event edge loads 1.
        PINS[1] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (pred_chg() != 0) begin
                wr(2'd3, 32'h0);
                found = 1'b1;
                check("EV_WRITE_EVENT", dut_reg[3], 32'h1);
            end else begin
                step();
            end
        end
        check("EV_WRITE_ALIGNED", {31'd0, found}, 32'h1);

        // Reset with two of three samples of bit 7 collected.
        PINS[7] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            step();
            if (m_hist[SAMPLES-1][7] && m_hist[SAMPLES-2][7] && !m_hist[SAMPLES-3][7]) found = 1'b1;
        end
        check("MIDRST_ALIGNED", {31'd0, found}, 32'h1);
        RST = 1'b1;
        model_reset();
        check_all_zero("MIDRST");
        repeat (2) step();
        RST = 1'b0;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (first == 0 && dut_reg[0][7]) first = n;
        end
        check("MIDRST_FRESH", {31'd0, first >= 2 + (SAMPLES - 1) * DIV + 1}, 32'd1);
        check("MIDRST_WITHIN", {31'd0, first != 0 && first <= 2 + SAMPLES * DIV}, 32'd1);

        // Random pin activity and bus traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) == 0) PINS ^= (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) PINS = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                SEL     = ($urandom_range(0, 3) != 0);
                WE      = ($urandom_range(0, 3) != 0);
                ADDRESS = 2'($urandom_range(0, 3));
                DATAIN  = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
